// File: rtl/mpu_arb_pkg.sv
// mpu_arb_pkg: FSM states, op encoding and perf counter width shared by mpu_mem_arbiter.
package mpu_arb_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;
   localparam int CNT_W = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search for the first request at or after i_ptr,
// wrapping from N-1 back to 0; returns one-hot grant and its index.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);
   logic          w_found;
   logic [IW-1:0] w_c;
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_c     = '0;
      for (int k = 0; k < N; k++) begin
         w_c = IW'((int'(i_ptr) + k) % N);
         if (!w_found && i_req[w_c]) begin
            w_found    = 1'b1;
            o_gnt[w_c] = 1'b1;
            o_idx      = w_c;
         end
      end
   end
endmodule

// File: rtl/mpu_mem_arbiter.sv
// mpu_mem_arbiter: round-robin share of one HBM pseudo-channel among NUM_REQ MPUs, one transaction in flight.
// Optional MPU_ARB_PERF_EN adds saturating per-requester completion and busy-cycle counters.
module mpu_mem_arbiter
   import mpu_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int AddrWidth = 33,
   parameter int DataWidth = 256,
   parameter int IdxWidth  = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [NUM_REQ-1:0]             i_req_start_rd,
   input  logic [NUM_REQ*AddrWidth-1:0]   i_req_rd_addr,
   output logic [DataWidth-1:0]           o_req_rd_data,
   output logic [NUM_REQ-1:0]             o_req_end_rd,
   input  logic [NUM_REQ-1:0]             i_req_start_wr,
   input  logic [NUM_REQ*AddrWidth-1:0]   i_req_wr_addr,
   input  logic [NUM_REQ*DataWidth-1:0]   i_req_wr_data,
   output logic [NUM_REQ-1:0]             o_req_end_wr,
   output logic                           o_mem_start_rd,
   output logic                           o_mem_start_wr,
   output logic [AddrWidth-1:0]           o_mem_addr,
   output logic [DataWidth-1:0]           o_mem_wr_data,
   input  logic [DataWidth-1:0]           i_mem_rd_data,
   input  logic                           i_mem_end_rd,
   input  logic                           i_mem_end_wr,
`ifdef MPU_ARB_PERF_EN
   output logic [NUM_REQ*CNT_W-1:0]       o_perf_grants,
   output logic [CNT_W-1:0]               o_perf_busy_cyc,
`endif
   output logic                           o_busy
);
   state_t                r_state, w_state_nxt;
   logic [NUM_REQ-1:0]    r_rd_pend, r_wr_pend, w_req, w_gnt_oh;
   logic [NUM_REQ-1:0]    w_clr_rd, w_clr_wr, w_cap_rd, w_cap_wr;
   logic [IdxWidth-1:0]   r_ptr, r_gnt_idx, w_arb_idx, w_ptr_nxt;
   logic                  r_op, w_done, w_busy;
   logic [AddrWidth-1:0]  r_rd_addr [NUM_REQ];
   logic [AddrWidth-1:0]  r_wr_addr [NUM_REQ];
   logic [DataWidth-1:0]  r_wr_data [NUM_REQ];

   assign w_req     = r_rd_pend | r_wr_pend;
   assign w_busy    = (r_state != S_IDLE);
   assign w_done    = (r_state == S_WAIT) && ((r_op == OP_WR) ? i_mem_end_wr : i_mem_end_rd);
   assign w_clr_rd  = (w_done && r_op == OP_RD) ? NUM_REQ'(1) << r_gnt_idx : '0;
   assign w_clr_wr  = (w_done && r_op == OP_WR) ? NUM_REQ'(1) << r_gnt_idx : '0;
   // A start in the cycle its flag clears is a fresh request, not a duplicate
   assign w_cap_rd  = i_req_start_rd & (~r_rd_pend | w_clr_rd);
   assign w_cap_wr  = i_req_start_wr & (~r_wr_pend | w_clr_wr);
   assign w_ptr_nxt = (r_gnt_idx == IdxWidth'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
   assign o_busy    = w_busy;

   rr_arbiter #(.N(NUM_REQ), .IW(IdxWidth)) u_rr (
      .i_req (w_req),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt_oh),
      .o_idx (w_arb_idx)
   );

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_state_nxt = (r_state == S_IDLE && |w_req) ? S_ISSUE :
                    (r_state == S_ISSUE)          ? S_WAIT  :
                    w_done                        ? S_IDLE  : r_state;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_cap_rd[i]) r_rd_addr[i] <= i_req_rd_addr[i*AddrWidth +: AddrWidth];
         if (w_cap_wr[i]) begin
            r_wr_addr[i] <= i_req_wr_addr[i*AddrWidth +: AddrWidth];
            r_wr_data[i] <= i_req_wr_data[i*DataWidth +: DataWidth];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rd_pend      <= '0;
         r_wr_pend      <= '0;
         r_ptr          <= '0;
         r_gnt_idx      <= '0;
         r_op           <= OP_RD;
         o_mem_start_rd <= 1'b0;
         o_mem_start_wr <= 1'b0;
         o_mem_addr     <= '0;
         o_mem_wr_data  <= '0;
         o_req_rd_data  <= '0;
         o_req_end_rd   <= '0;
         o_req_end_wr   <= '0;
      end else begin
         r_rd_pend      <= (r_rd_pend & ~w_clr_rd) | i_req_start_rd;
         r_wr_pend      <= (r_wr_pend & ~w_clr_wr) | i_req_start_wr;
         o_mem_start_rd <= (r_state == S_ISSUE) && (r_op == OP_RD);
         o_mem_start_wr <= (r_state == S_ISSUE) && (r_op == OP_WR);
         o_req_end_rd   <= w_clr_rd;
         o_req_end_wr   <= w_clr_wr;
         if (r_state == S_IDLE && |w_req) begin
            r_gnt_idx <= w_arb_idx;
            r_op      <= |(r_wr_pend & w_gnt_oh) ? OP_WR : OP_RD;
         end
         if (r_state == S_ISSUE) begin
            o_mem_addr    <= (r_op == OP_WR) ? r_wr_addr[r_gnt_idx] : r_rd_addr[r_gnt_idx];
            o_mem_wr_data <= r_wr_data[r_gnt_idx];
         end
         if (w_done && r_op == OP_RD) o_req_rd_data <= i_mem_rd_data;
         if (w_done) r_ptr <= w_ptr_nxt;
      end
   end

`ifdef MPU_ARB_PERF_EN
   logic [NUM_REQ*CNT_W-1:0] r_perf_grants;
   logic [CNT_W-1:0]         r_perf_busy;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_perf_grants <= '0;
         r_perf_busy   <= '0;
      end else begin
         if (w_busy && !(&r_perf_busy)) r_perf_busy <= r_perf_busy + 1'b1;
         for (int i = 0; i < NUM_REQ; i++)
            if ((w_clr_rd[i] | w_clr_wr[i]) && !(&r_perf_grants[i*CNT_W +: CNT_W]))
               r_perf_grants[i*CNT_W +: CNT_W] <= r_perf_grants[i*CNT_W +: CNT_W] + 1'b1;
      end
   end
   assign o_perf_grants   = r_perf_grants;
   assign o_perf_busy_cyc = r_perf_busy;
`endif
endmodule

// File: tb/tb_mpu_mem_arbiter.sv
// tb_mpu_mem_arbiter: directed self-checking bench for mpu_mem_arbiter (default build).
module tb_mpu_mem_arbiter;
   localparam int N  = 4;
   localparam int AW = 33;
   localparam int DW = 256;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic [N-1:0]    req_start_rd = '0, req_start_wr = '0;
   logic [N*AW-1:0] req_rd_addr = '0, req_wr_addr = '0;
   logic [N*DW-1:0] req_wr_data = '0;
   logic [DW-1:0]   req_rd_data, mem_wr_data;
   logic [DW-1:0]   mem_rd_data = '0;
   logic [N-1:0]    req_end_rd, req_end_wr;
   logic            mem_start_rd, mem_start_wr, busy;
   logic            mem_end_rd = 1'b0, mem_end_wr = 1'b0;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   last_rd = '0;
   int              n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   mpu_mem_arbiter #(.NUM_REQ(N), .AddrWidth(AW), .DataWidth(DW), .IdxWidth(2)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .i_req_start_rd (req_start_rd),
      .i_req_rd_addr  (req_rd_addr),
      .o_req_rd_data  (req_rd_data),
      .o_req_end_rd   (req_end_rd),
      .i_req_start_wr (req_start_wr),
      .i_req_wr_addr  (req_wr_addr),
      .i_req_wr_data  (req_wr_data),
      .o_req_end_wr   (req_end_wr),
      .o_mem_start_rd (mem_start_rd),
      .o_mem_start_wr (mem_start_wr),
      .o_mem_addr     (mem_addr),
      .o_mem_wr_data  (mem_wr_data),
      .i_mem_rd_data  (mem_rd_data),
      .i_mem_end_rd   (mem_end_rd),
      .i_mem_end_wr   (mem_end_wr),
      .o_busy         (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd_req(input int i, input logic [AW-1:0] a);
      req_start_rd[i] = 1'b1;
      req_rd_addr[i*AW +: AW] = a;
   endtask

   task automatic wr_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_start_wr[i] = 1'b1;
      req_wr_addr[i*AW +: AW] = a;
      req_wr_data[i*DW +: DW] = d;
   endtask

   task automatic pulse();
      tick();
      req_start_rd = '0;
      req_start_wr = '0;
   endtask

   // Waits (bounded) for the next mem_start, checks it, then injects a wrong-type mem_end
   task automatic wait_issue(input string tag, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int k = 0;
      while (!(mem_start_rd || mem_start_wr) && k < 20) begin
         tick();
         k++;
      end
      chk({tag, "_start"}, DW'(mem_start_rd | mem_start_wr), DW'(1));
      chk({tag, "_op"}, DW'(mem_start_wr), DW'(wr));
      chk({tag, "_addr"}, DW'(mem_addr), DW'(a));
      if (wr) chk({tag, "_wdata"}, mem_wr_data, d);
      tick();
      chk({tag, "_pulse1"}, DW'({mem_start_rd, mem_start_wr}), DW'(0));
      if (wr) mem_end_rd = 1'b1;
      else    mem_end_wr = 1'b1;
      tick();
      mem_end_rd = 1'b0;
      mem_end_wr = 1'b0;
      chk({tag, "_wrongend"}, DW'({req_end_rd, req_end_wr, busy}), DW'(9'h001));
   endtask

   task automatic finish_txn(input string tag, input logic wr, input int i, input logic [DW-1:0] rd);
      logic [N-1:0] oh;
      oh = N'(1) << i;
      if (wr) mem_end_wr = 1'b1;
      else begin
         mem_end_rd  = 1'b1;
         mem_rd_data = rd;
      end
      tick();
      mem_end_rd   = 1'b0;
      mem_end_wr   = 1'b0;
      req_start_rd = '0;
      req_start_wr = '0;
      if (!wr) last_rd = rd;
      chk({tag, "_end_rd"}, DW'(req_end_rd), DW'(wr ? '0 : oh));
      chk({tag, "_end_wr"}, DW'(req_end_wr), DW'(wr ? oh : '0));
      chk({tag, "_rdata"}, req_rd_data, last_rd);
      tick();
      chk({tag, "_endclr"}, DW'({req_end_rd, req_end_wr}), DW'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic seen;
      tick();
      tick();
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_mem_start", DW'({mem_start_rd, mem_start_wr}), DW'(0));
      chk("rst_req_end", DW'({req_end_rd, req_end_wr}), DW'(0));
      chk("rst_rd_data", req_rd_data, '0);
      chk("rst_mem_addr", DW'(mem_addr), DW'(0));
      resetn = 1'b1;
      tick();

      // single read, start at t -> mem_start at t+3, mem_end 5 cycles later
      rd_req(1, 33'h1_0000_0040);
      pulse();
      chk("t1_idle_t1", DW'(busy), DW'(0));
      tick();
      chk("t1_busy_t2", DW'({busy, mem_start_rd}), DW'(2'b10));
      tick();
      chk("t1_start_t3", DW'(mem_start_rd), DW'(1));
      wait_issue("t1", 1'b0, 33'h1_0000_0040, '0);
      repeat (3) tick();
      finish_txn("t1", 1'b0, 1, {32{8'hA5}});
      chk("t1_idle", DW'(busy), DW'(0));

      // simultaneous reads from all MPUs with pointer back at 0
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      last_rd = '0;
      tick();
      for (int i = 0; i < N; i++) rd_req(i, AW'(33'h100 * (i + 1)));
      pulse();
      for (int i = 0; i < N; i++) begin
         wait_issue($sformatf("t2_%0d", i), 1'b0, AW'(33'h100 * (i + 1)), '0);
         finish_txn($sformatf("t2_%0d", i), 1'b0, i, DW'(64'hC0DE_0000_0000_0000 + i));
      end

      // after MPU1 grant pointer=2: MPU3 beats MPU0
      rd_req(1, 33'h140);
      pulse();
      wait_issue("t3_m1", 1'b0, 33'h140, '0);
      finish_txn("t3_m1", 1'b0, 1, DW'(256'h1111));
      rd_req(0, 33'h200);
      rd_req(3, 33'h3_0000);
      pulse();
      wait_issue("t3_m3", 1'b0, 33'h3_0000, '0);
      finish_txn("t3_m3", 1'b0, 3, DW'(256'h3333));
      wait_issue("t3_m0", 1'b0, 33'h200, '0);
      finish_txn("t3_m0", 1'b0, 0, DW'(256'h0000_BEEF));

      // write and read pending on MPU2: write first, read data held across the write
      wr_req(2, 33'h80, 256'h1234);
      rd_req(2, 33'h2000);
      pulse();
      wait_issue("t4_wr", 1'b1, 33'h80, 256'h1234);
      finish_txn("t4_wr", 1'b1, 2, '0);
      wait_issue("t4_rd", 1'b0, 33'h2000, '0);
      finish_txn("t4_rd", 1'b0, 2, DW'(256'h4444_5555));

      // duplicate start while pending keeps the first address
      rd_req(0, 33'h300);
      pulse();
      rd_req(0, 33'h400);
      pulse();
      wait_issue("t5", 1'b0, 33'h300, '0);
      finish_txn("t5", 1'b0, 0, DW'(256'h5555));
      seen = 1'b0;
      repeat (6) begin
         tick();
         seen = seen | mem_start_rd | mem_start_wr | (|req_end_rd);
      end
      chk("t5_nodup", DW'({seen, busy}), DW'(0));

      // start in the same cycle the flag clears is a new request
      rd_req(3, 33'h500);
      pulse();
      wait_issue("t7a", 1'b0, 33'h500, '0);
      rd_req(3, 33'h600);
      finish_txn("t7a", 1'b0, 3, DW'(256'h7777));
      wait_issue("t7b", 1'b0, 33'h600, '0);
      finish_txn("t7b", 1'b0, 3, DW'(256'h7878));

      // reset during WAIT, then a late mem_end
      rd_req(1, 33'h700);
      pulse();
      wait_issue("t6", 1'b0, 33'h700, '0);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      last_rd = '0;
      mem_end_rd = 1'b1;
      mem_rd_data = DW'(256'h6666);
      tick();
      mem_end_rd = 1'b0;
      chk("t6_noend", DW'({req_end_rd, req_end_wr, busy}), DW'(0));
      chk("t6_rdata", req_rd_data, '0);
      seen = 1'b0;
      repeat (4) begin
         tick();
         seen = seen | mem_start_rd | mem_start_wr | (|req_end_rd) | busy;
      end
      chk("t6_quiet", DW'(seen), DW'(0));
      rd_req(2, 33'h800);
      pulse();
      wait_issue("t6_after", 1'b0, 33'h800, '0);
      finish_txn("t6_after", 1'b0, 2, DW'(256'h9999));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
